// File: rtl/versat_select_sequencer_pkg.sv
// Shared definitions for Versat selector units: FSM state encoding and the
// pattern-length field width derivation.
package versat_select_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StActive = 2'd2
    } state_e;

    // The length field must hold the value PAT_W itself, hence the extra bit.
    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/versat_select_sequencer_if.sv
// Configuration/control and result signals between the accelerator controller
// and a select sequencer.
interface versat_select_sequencer_if
    import versat_select_sequencer_pkg::*;
#(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned PAT_W   = 32
) ();

    localparam int unsigned LEN_W = len_w(PAT_W);

    logic               running;
    logic               run;
    logic [DELAY_W-1:0] delay;
    logic [PAT_W-1:0]   pattern;
    logic [LEN_W-1:0]   length;
    logic [DELAY_W-1:0] period;
    logic [DELAY_W-1:0] iterations;
    logic [31:0]        out0;
    logic               done;

    modport master (
        output running, run, delay, pattern, length, period, iterations,
        input  out0, done
    );

    modport slave (
        input  running, run, delay, pattern, length, period, iterations,
        output out0, done
    );

endinterface

// File: rtl/versat_select_sequencer_cnt.sv
// Loadable down-counter that saturates at zero; zero flag reflects the
// registered count.
module versat_select_sequencer_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [Width-1:0] load_val,
    output logic             zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/versat_select_sequencer.sv
// Versat select sequencer: after a start delay, plays a latched bit pattern on
// out0[0], each bit held for `period` cycles, repeated `iterations` times.
module versat_select_sequencer
    import versat_select_sequencer_pkg::*;
#(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned PAT_W   = 32
) (
    input logic                      clk,
    input logic                      rst,
    versat_select_sequencer_if.slave bus
);

    localparam int unsigned LEN_W = len_w(PAT_W);
    localparam logic [LEN_W-1:0] PatLen = LEN_W'(PAT_W);

    state_e             state_q;
    logic               sel_q;
    logic               done_q;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   sr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   bit_q;
    logic [DELAY_W-1:0] per_q;
    logic [DELAY_W-1:0] iter_q;

    logic [LEN_W-1:0]   len_san;
    logic [DELAY_W-1:0] per_san;
    logic [DELAY_W-1:0] dly_val;
    logic [DELAY_W-1:0] per_val;
    logic [DELAY_W-1:0] iter_val;
    logic [PAT_W-1:0]   sr_shift;
    logic               last_bit;
    logic               dly_zero;
    logic               per_zero;
    logic               iter_zero;
    logic               dly_en;
    logic               per_load;
    logic               per_en;
    logic               iter_en;

    // Length 0 plays one bit; oversize lengths clamp to the pattern width.
    always_comb begin
        len_san = bus.length;
        if (bus.length == '0) begin
            len_san = LEN_W'(1);
        end else if (bus.length > PatLen) begin
            len_san = PatLen;
        end
    end

    always_comb begin
        per_san  = (bus.period == '0) ? DELAY_W'(1) : bus.period;
        dly_val  = (bus.delay == '0) ? '0 : bus.delay - DELAY_W'(1);
        iter_val = (bus.iterations == '0) ? '0 : bus.iterations - DELAY_W'(1);
        per_val  = bus.run ? per_san - DELAY_W'(1) : per_q - DELAY_W'(1);
        sr_shift = sr_q >> 1;
        last_bit = (bit_q == len_q - LEN_W'(1));
    end

    // Counters hold "remaining cycles minus one", so each expires on its zero flag.
    always_comb begin
        dly_en   = (state_q == StDelay);
        per_en   = (state_q == StActive);
        per_load = bus.run || (dly_en && dly_zero) || (per_en && per_zero);
        iter_en  = per_en && per_zero && last_bit;
    end

    versat_select_sequencer_cnt #(
        .Width(DELAY_W)
    ) u_dly_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.run),
        .en      (dly_en),
        .load_val(dly_val),
        .zero    (dly_zero)
    );

    versat_select_sequencer_cnt #(
        .Width(DELAY_W)
    ) u_per_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (per_load),
        .en      (per_en),
        .load_val(per_val),
        .zero    (per_zero)
    );

    versat_select_sequencer_cnt #(
        .Width(DELAY_W)
    ) u_iter_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.run),
        .en      (iter_en),
        .load_val(iter_val),
        .zero    (iter_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            done_q  <= 1'b1;
            pat_q   <= '0;
            sr_q    <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            iter_q  <= '0;
        end else if (bus.run) begin
            pat_q  <= bus.pattern;
            sr_q   <= bus.pattern;
            len_q  <= len_san;
            per_q  <= per_san;
            iter_q <= bus.iterations;
            bit_q  <= '0;
            if (bus.delay != '0) begin
                state_q <= StDelay;
                sel_q   <= 1'b0;
                done_q  <= 1'b0;
            end else if (bus.iterations == '0) begin
                state_q <= StIdle;
                sel_q   <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= StActive;
                sel_q   <= bus.pattern[0];
                done_q  <= 1'b0;
            end
        end else if ((state_q != StIdle) && !bus.running) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            done_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sel_q  <= 1'b0;
                    done_q <= 1'b1;
                end
                StDelay: begin
                    if (dly_zero) begin
                        if (iter_q == '0) begin
                            state_q <= StIdle;
                            sel_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StActive;
                            sel_q   <= pat_q[0];
                            sr_q    <= pat_q;
                            bit_q   <= '0;
                        end
                    end
                end
                StActive: begin
                    if (per_zero) begin
                        if (last_bit) begin
                            if (iter_zero) begin
                                state_q <= StIdle;
                                sel_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                bit_q <= '0;
                                sr_q  <= pat_q;
                                sel_q <= pat_q[0];
                            end
                        end else begin
                            bit_q <= bit_q + LEN_W'(1);
                            sr_q  <= sr_shift;
                            sel_q <= sr_shift[0];
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    sel_q   <= 1'b0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out0 = {31'b0, sel_q};
    assign bus.done = done_q;

endmodule

// File: tb/tb_versat_select_sequencer.sv
// Directed bench for versat_select_sequencer: hand-computed per-cycle out0/done
// sequences for normal runs, sanitised config, re-run, abort and reset.
module tb_versat_select_sequencer;
    import versat_select_sequencer_pkg::*;

    localparam int unsigned DELAY_W = 16;
    localparam int unsigned PAT_W   = 32;
    localparam int unsigned LEN_W   = len_w(PAT_W);

    logic clk = 1'b0;
    logic rst;

    versat_select_sequencer_if #(.DELAY_W(DELAY_W), .PAT_W(PAT_W)) bus ();

    versat_select_sequencer #(
        .DELAY_W(DELAY_W),
        .PAT_W  (PAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_cfg(input logic [DELAY_W-1:0] d, input logic [PAT_W-1:0] pat,
                             input logic [LEN_W-1:0] len, input logic [DELAY_W-1:0] per,
                             input logic [DELAY_W-1:0] it);
        bus.delay      = d;
        bus.pattern    = pat;
        bus.length     = len;
        bus.period     = per;
        bus.iterations = it;
    endtask

    // Called at a negedge in cycle T; returns at the negedge of cycle T+1.
    // Config is scrambled afterwards since it must be ignored while run is low.
    task automatic pulse_run(input logic [DELAY_W-1:0] d, input logic [PAT_W-1:0] pat,
                             input logic [LEN_W-1:0] len, input logic [DELAY_W-1:0] per,
                             input logic [DELAY_W-1:0] it);
        drive_cfg(d, pat, len, per, it);
        bus.run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        drive_cfg(16'd7, 32'hFFFF_FFFF, 6'd3, 16'd5, 16'd9);
    endtask

    // bits[i]/dones[i] are the expected out0[0]/done at cycle T+1+i.
    task automatic expect_seq(input string tag, input int n, input logic [63:0] bits,
                              input logic [63:0] dones);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_out0_c%0d", tag, i + 1), bus.out0, {31'b0, bits[i]});
            check_val($sformatf("%s_done_c%0d", tag, i + 1), {31'b0, bus.done},
                      {31'b0, dones[i]});
            @(negedge clk);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.running = 1'b1;
        bus.run     = 1'b1;
        drive_cfg(16'd0, 32'hB, 6'd4, 16'd1, 16'd2);

        // Reset held two cycles with run asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val($sformatf("rst_out0_%0d", i), bus.out0, 32'h0);
            check_val($sformatf("rst_done_%0d", i), {31'b0, bus.done}, 32'h1);
        end
        rst     = 1'b0;
        bus.run = 1'b0;
        @(negedge clk);
        expect_seq("post_rst", 3, 64'h0, 64'h7);

        // Basic run: 1011, L=4, P=1, D=0, I=2
        pulse_run(16'd0, 32'hB, 6'd4, 16'd1, 16'd2);
        expect_seq("basic", 9, 64'h0BB, 64'h100);

        // Delay + period: 10, L=2, P=2, D=3, I=1
        pulse_run(16'd3, 32'h2, 6'd2, 16'd2, 16'd1);
        expect_seq("dly_per", 8, 64'h60, 64'h80);

        // Zero iterations: only the delay elapses
        pulse_run(16'd2, 32'hF, 6'd4, 16'd1, 16'd0);
        expect_seq("iter0", 3, 64'h0, 64'h4);

        // length=0 and period=0 both act as 1
        pulse_run(16'd0, 32'h1, 6'd0, 16'd0, 16'd3);
        expect_seq("len0_per0", 4, 64'h7, 64'h8);

        // Oversize length clamps to 32 bits
        pulse_run(16'd0, 32'h8000_0001, 6'd40, 16'd1, 16'd1);
        expect_seq("len_clamp", 33, 64'h8000_0001, 64'h1_0000_0000);

        // Re-run at T+4 with an all-zero pattern restarts from scratch
        pulse_run(16'd0, 32'hB, 6'd4, 16'd1, 16'd2);
        expect_seq("rerun_a", 3, 64'h3, 64'h0);
        pulse_run(16'd0, 32'h0, 6'd4, 16'd1, 16'd2);
        expect_seq("rerun_b", 9, 64'h0, 64'h100);

        // Abort via running low at T+3
        pulse_run(16'd3, 32'h2, 6'd2, 16'd2, 16'd1);
        expect_seq("abort_pre", 2, 64'h0, 64'h0);
        bus.running = 1'b0;
        @(negedge clk);
        bus.running = 1'b1;
        expect_seq("abort", 5, 64'h0, 64'h1F);

        // Same point, reset instead of abort
        pulse_run(16'd3, 32'h2, 6'd2, 16'd2, 16'd1);
        expect_seq("rst_mid_pre", 2, 64'h0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_seq("rst_mid", 5, 64'h0, 64'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
